// File: rtl/div32x32.sv
`default_nettype none
// ============================================================================
//  Module      : div32x32
//  Description : Sequential unsigned WIDTH/WIDTH radix-2 restoring divider.
//                One quotient bit per clock, start/busy/done handshake,
//                quotient, remainder and divide-by-zero flag returned after
//                a fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module div32x32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   divisor;

  // q doubles as the dividend/quotient shift register and r as the partial
  // remainder, so the visible results are only meaningful outside CALC.
  logic [WIDTH:0]     trial_src;
  logic [WIDTH:0]     trial;

  // Trial subtraction is one bit wider than the operands so divisors above
  // 2^(WIDTH-1) still produce a correct borrow.
  always_comb begin
    trial_src = {r, q[WIDTH-1]};
    trial     = trial_src - {1'b0, divisor};
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      divisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (b != '0) begin
              q        <= a;
              divisor  <= b;
              r        <= '0;
              cnt      <= '0;
              div_zero <= 1'b0;
              state    <= CALC;
            end else begin
              // Divide-by-zero short-circuits straight to the result cycle.
              q        <= '1;
              r        <= a;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        CALC: begin
          q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
          r   <= trial[WIDTH] ? trial_src[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div32x32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div32x32
//  Description : Directed and random self-checking bench for div32x32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div32x32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  int tests;
  int fails;
  int cyc;

  div32x32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse; lat counts edges from the accepting edge up to and
  // including the edge after which done is observed (40 = timed out).
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, output int lat);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 32'd77;
    b = 32'd5;
    tick();
    tick();
    tests++;
    if ({busy, done, div_zero} !== 3'b000 || q !== 32'd0 || r !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h, expected all zero",
               busy, done, div_zero, q, r);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_start: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_op(32'd100, 32'd7, lat);
    tests++;
    if (lat !== 33) begin
      fails++;
      $display("FAIL basic_latency: got %0d expected 33", lat);
    end
    tests++;
    if (q !== 32'd14 || r !== 32'd2 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0", q, r, div_zero);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_in_done: got %b expected 1", busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (q !== 32'd14 || r !== 32'd2 || done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL basic_hold[%0d]: got q=%0d r=%0d done=%b busy=%b expected 14 2 0 0",
                 i, q, r, done, busy);
      end
    end
  endtask

  task automatic test_edges();
    int lat;
    do_op(32'hFFFF_FFFF, 32'h8000_0001, lat);
    tests++;
    if (lat !== 33 || q !== 32'd1 || r !== 32'h7FFF_FFFE) begin
      fails++;
      $display("FAIL big_divisor: got lat=%0d q=%h r=%h expected 33 00000001 7ffffffe", lat, q, r);
    end
    tick();
    do_op(32'd5, 32'd9, lat);
    tests++;
    if (q !== 32'd0 || r !== 32'd5) begin
      fails++;
      $display("FAIL a_lt_b: got q=%0d r=%0d expected 0 5", q, r);
    end
    tick();
    do_op(32'hFFFF_FFFF, 32'd1, lat);
    tests++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd0) begin
      fails++;
      $display("FAIL div_by_one: got q=%h r=%h expected ffffffff 0", q, r);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(32'd1234, 32'd0, lat);
    tests++;
    if (lat !== 1 || q !== 32'hFFFF_FFFF || r !== 32'd1234 || div_zero !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL div_zero: got lat=%0d q=%h r=%0d dz=%b busy=%b expected 1 ffffffff 1234 1 1",
               lat, q, r, div_zero, busy);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL div_zero_return: got done=%b busy=%b expected 0 0", done, busy);
    end
    do_op(32'd9, 32'd3, lat);
    tests++;
    if (q !== 32'd3 || r !== 32'd0 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL after_div_zero: got q=%0d r=%0d dz=%b expected 3 0 0", q, r, div_zero);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int last_done;
    int waited;
    a = 32'd50;
    b = 32'd6;
    start = 1'b1;
    last_done = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      a = 32'd1000;
      b = 32'd3;
      repeat (3) tick();
      a = 32'd50;
      b = 32'd6;
      waited = 0;
      while (!done && waited < 40) begin
        tick();
        waited++;
      end
      if (k == 2) start = 1'b0;
      tests++;
      if (done !== 1'b1 || q !== 32'd8 || r !== 32'd2) begin
        fails++;
        $display("FAIL b2b_result[%0d]: got done=%b q=%0d r=%0d expected 1 8 2", k, done, q, r);
      end
      if (k > 0) begin
        tests++;
        if (cyc - last_done !== 34) begin
          fails++;
          $display("FAIL b2b_period[%0d]: got %0d expected 34", k, cyc - last_done);
        end
      end
      last_done = cyc;
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_single_cycle: got %b expected 0", done);
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({busy, done, div_zero} !== 3'b000 || q !== 32'd0 || r !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b dz=%b q=%h r=%h expected all zero",
               busy, done, div_zero, q, r);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_discard: got %0d active cycles expected 0", seen);
    end
    do_op(32'd81, 32'd9, lat);
    tests++;
    if (lat !== 33 || q !== 32'd9 || r !== 32'd0) begin
      fails++;
      $display("FAIL after_reset_mid: got lat=%0d q=%0d r=%0d expected 33 9 0", lat, q, r);
    end
    tick();
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eq;
    logic [31:0] er;
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 19))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 16);
        3:       rb = ra + 32'd1;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (rb == 32'd0) begin
        eq = 32'hFFFF_FFFF;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      do_op(ra, rb, lat);
      tests++;
      if (q !== eq || r !== er || div_zero !== (rb == 32'd0) || lat !== ((rb == 32'd0) ? 1 : 33)) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h",
                 i, ra, rb, q, r, div_zero, lat, eq, er);
      end
      tick();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
